// File: rtl/data_mem_if_if.sv
// Data-memory bus bundle between the load/store unit (master) and the memory
// or bus fabric (slave). Signal names follow the master's point of view.
interface data_mem_if_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_be_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_be_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/data_mem_if.sv
// Load/store bus adapter: turns a pipeline memory request into a single
// request/ack bus transaction with timeout, stalling the pipeline meanwhile.
module data_mem_if #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          read_i,
    input  logic          write_i,
    input  logic          exception_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    mask_i,
    output logic          stall_o,
    output logic          done_o,
    output logic          bus_err_o,
    output logic [31:0]   rdata_o,
    data_mem_if_if.master mem
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The abort fires in the REQ cycle whose starting count is TIMEOUT_CYCLES-1,
    // i.e. after exactly TIMEOUT_CYCLES REQ cycles without an ack.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        we_q, we_d;
    logic [29:0] word_q, word_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        stall_d;

    logic valid_req;
    logic illegal_req;
    logic unused_addr_bits;

    assign valid_req        = (read_i | write_i) & ~exception_i;
    assign illegal_req      = read_i & write_i & ~exception_i;
    assign unused_addr_bits = ^addr_i[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 8'd0;
            we_q       <= 1'b0;
            word_q     <= 30'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            word_q     <= word_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        word_d     = word_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        stall_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (illegal_req) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    stall_d = 1'b1;
                end else if (valid_req) begin
                    state_d    = REQ;
                    wait_cnt_d = 8'd0;
                    we_d       = write_i;
                    word_d     = addr_i[31:2];
                    be_d       = mask_i;
                    wdata_d    = wdata_i;
                    stall_d    = 1'b1;
                end
            end

            REQ: begin
                stall_d = 1'b1;
                // Ack is checked first so that it beats a coincident timeout.
                if (mem.mem_ack_i) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = mem.mem_rdata_i;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // stall is gated by rst so the pipeline is released while reset is held.
    assign stall_o   = stall_d & ~rst;
    assign done_o    = (state_q == DONE);
    assign bus_err_o = err_q;
    assign rdata_o   = rdata_q;

    assign mem.mem_req_o   = (state_q == REQ);
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = {word_q, 2'b00};
    assign mem.mem_be_o    = be_q;
    assign mem.mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_data_mem_if.sv
// Cycle-by-cycle vector bench for data_mem_if with TIMEOUT_CYCLES = 4.
module tb_data_mem_if;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_i = 1'b0;
    logic        write_i = 1'b0;
    logic        exception_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [3:0]  mask_i = 4'd0;
    logic        stall_o;
    logic        done_o;
    logic        bus_err_o;
    logic [31:0] rdata_o;

    data_mem_if_if bus();

    data_mem_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .read_i      (read_i),
        .write_i     (write_i),
        .exception_i (exception_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .mask_i      (mask_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .bus_err_o   (bus_err_o),
        .rdata_o     (rdata_o),
        .mem         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, exc;
        logic [3:0]  mask;
        logic [31:0] addr, wdata;
        logic        ack;
        logic [31:0] mrdata;
        logic        e_stall, e_done, e_err, e_req, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_rdata;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [31:0] D = 32'hDEADBEEF;
    localparam logic [31:0] C = 32'hCAFEF00D;
    localparam logic [31:0] B = 32'h0BADF00D;

    function automatic vec_t mk(input logic rd, input logic wr, input logic exc, input logic [3:0] mask,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic ack,
                                input logic [31:0] mrdata, input logic e_stall, input logic e_done,
                                input logic e_err, input logic e_req, input logic e_we,
                                input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        vec_t t;
        t.rd = rd; t.wr = wr; t.exc = exc; t.mask = mask; t.addr = addr; t.wdata = wdata;
        t.ack = ack; t.mrdata = mrdata;
        t.e_stall = e_stall; t.e_done = e_done; t.e_err = e_err; t.e_req = e_req; t.e_we = e_we;
        t.e_addr = e_addr; t.e_be = e_be; t.e_wdata = e_wdata; t.e_rdata = e_rdata;
        return t;
    endfunction

    function automatic void v(input logic rd, input logic wr, input logic exc, input logic [3:0] mask,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic ack,
                              input logic [31:0] mrdata, input logic e_stall, input logic e_done,
                              input logic e_err, input logic e_req, input logic e_we,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        vecs.push_back(mk(rd, wr, exc, mask, addr, wdata, ack, mrdata, e_stall, e_done, e_err,
                          e_req, e_we, e_addr, e_be, e_wdata, e_rdata));
    endfunction

    // Bus-side fields (we/addr/be/wdata) only matter while a request is up,
    // unless full is set (reset checks require every output at zero).
    task automatic compare(input string name, input vec_t e, input bit full);
        logic [104:0] act, exp, care;
        act  = {stall_o, done_o, bus_err_o, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o,
                bus.mem_be_o, bus.mem_wdata_o, rdata_o};
        exp  = {e.e_stall, e.e_done, e.e_err, e.e_req, e.e_we, e.e_addr, e.e_be, e.e_wdata, e.e_rdata};
        care = {4'hF, {69{full | e.e_req}}, 32'hFFFFFFFF};
        checks++;
        if ((act & care) !== (exp & care)) begin
            errors++;
            $display("FAIL %s: got %h required %h (stall,done,err,req,we,addr,be,wdata,rdata)",
                     name, act & care, exp & care);
        end else begin
            $display("%s ok: stall=%0b done=%0b err=%0b req=%0b rdata=%h",
                     name, stall_o, done_o, bus_err_o, bus.mem_req_o, rdata_o);
        end
    endtask

    task automatic drive(input vec_t t);
        read_i          = t.rd;
        write_i         = t.wr;
        exception_i     = t.exc;
        mask_i          = t.mask;
        addr_i          = t.addr;
        wdata_i         = t.wdata;
        bus.mem_ack_i   = t.ack;
        bus.mem_rdata_i = t.mrdata;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            compare($sformatf("%s[%0d]", tag, i), vecs[i], 1'b0);
        end
        vecs.delete();
    endtask

    initial begin
        vec_t z;
        z = mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("reset", z, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // idle
        v(0,0,0,4'h0,32'h0,32'h0,0,32'h0,            0,0,0,0,0,32'h0,4'h0,32'h0,32'h0);
        // load 0x104, ack on first REQ cycle; request held through DONE must be ignored
        v(1,0,0,4'hF,32'h104,32'h0,0,32'h0,          1,0,0,0,0,32'h0,4'h0,32'h0,32'h0);
        v(1,0,0,4'hF,32'h104,32'h0,1,D,              1,0,0,1,0,32'h104,4'hF,32'h0,32'h0);
        v(1,0,0,4'hF,32'h104,32'h0,0,32'h0,          0,1,0,0,0,32'h0,4'h0,32'h0,D);
        v(0,0,0,4'h0,32'h0,32'h0,0,32'h0,            0,0,0,0,0,32'h0,4'h0,32'h0,D);
        // store 0x203 byte 3, three wait cycles then ack; read data on bus ignored
        v(0,1,0,4'h8,32'h203,32'hAA000000,0,32'h0,   1,0,0,0,0,32'h0,4'h0,32'h0,D);
        repeat (3)
        v(0,1,0,4'h8,32'h203,32'hAA000000,0,32'h0,   1,0,0,1,1,32'h200,4'h8,32'hAA000000,D);
        v(0,1,0,4'h8,32'h203,32'hAA000000,1,32'h12345678, 1,0,0,1,1,32'h200,4'h8,32'hAA000000,D);
        v(0,0,0,4'h0,32'h0,32'h0,0,32'h0,            0,1,0,0,0,32'h0,4'h0,32'h0,D);
        // read 0x300 with no ack: abort after 4 REQ cycles
        v(1,0,0,4'hF,32'h300,32'h0,0,32'h0,          1,0,0,0,0,32'h0,4'h0,32'h0,D);
        repeat (4)
        v(1,0,0,4'hF,32'h300,32'h0,0,32'h0,          1,0,0,1,0,32'h300,4'hF,32'h0,D);
        v(0,0,0,4'h0,32'h0,32'h0,0,32'h0,            0,1,1,0,0,32'h0,4'h0,32'h0,D);
        // read 0x008 with ack in the 4th REQ cycle: ack wins
        v(1,0,0,4'hF,32'h8,32'h0,0,32'h0,            1,0,0,0,0,32'h0,4'h0,32'h0,D);
        repeat (3)
        v(1,0,0,4'hF,32'h8,32'h0,0,32'h0,            1,0,0,1,0,32'h8,4'hF,32'h0,D);
        v(1,0,0,4'hF,32'h8,32'h0,1,C,                1,0,0,1,0,32'h8,4'hF,32'h0,D);
        v(0,0,0,4'h0,32'h0,32'h0,0,32'h0,            0,1,0,0,0,32'h0,4'h0,32'h0,C);
        // read and write together: straight to DONE with error
        v(1,1,0,4'hF,32'h400,32'h0,0,32'h0,          1,0,0,0,0,32'h0,4'h0,32'h0,C);
        v(0,0,0,4'h0,32'h0,32'h0,0,32'h0,            0,1,1,0,0,32'h0,4'h0,32'h0,C);
        v(0,0,0,4'h0,32'h0,32'h0,0,32'h0,            0,0,0,0,0,32'h0,4'h0,32'h0,C);
        // read and write with exception: suppressed entirely
        v(1,1,1,4'hF,32'h400,32'h0,0,32'h0,          0,0,0,0,0,32'h0,4'h0,32'h0,C);
        v(0,0,0,4'h0,32'h0,32'h0,0,32'h0,            0,0,0,0,0,32'h0,4'h0,32'h0,C);
        run_table("main");

        // exception on a load held for 10 cycles
        @(posedge clk);
        #1;
        read_i = 1'b1; exception_i = 1'b1; addr_i = 32'h700; mask_i = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({stall_o, bus.mem_req_o, done_o} !== 3'b000) begin
                errors++;
                $display("FAIL exc[%0d]: got stall/req/done=%b required 000", i,
                         {stall_o, bus.mem_req_o, done_o});
            end else begin
                $display("exc[%0d] ok: stall/req/done=000", i);
            end
        end
        @(posedge clk);
        #1;
        exception_i = 1'b0;
        addr_i = 32'h500;

        // reset asserted mid-REQ, ack afterwards ignored
        @(negedge clk);
        compare("rst_idle", mk(1,0,0,4'hF,32'h500,32'h0,0,32'h0, 1,0,0,0,0,32'h0,4'h0,32'h0,C), 1'b0);
        @(negedge clk);
        compare("rst_req", mk(1,0,0,4'hF,32'h500,32'h0,0,32'h0, 1,0,0,1,0,32'h500,4'hF,32'h0,C), 1'b0);
        #1;
        rst = 1'b1;
        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = 32'hFFFFFFFF;
        #1;
        compare("rst_async", z, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        read_i = 1'b0;

        v(0,0,0,4'h0,32'h0,32'h0,1,32'hFFFFFFFF,     0,0,0,0,0,32'h0,4'h0,32'h0,32'h0);
        v(0,0,0,4'h0,32'h0,32'h0,0,32'h0,            0,0,0,0,0,32'h0,4'h0,32'h0,32'h0);
        v(1,0,0,4'hF,32'h600,32'h0,0,32'h0,          1,0,0,0,0,32'h0,4'h0,32'h0,32'h0);
        v(1,0,0,4'hF,32'h600,32'h0,1,B,              1,0,0,1,0,32'h600,4'hF,32'h0,32'h0);
        v(0,0,0,4'h0,32'h0,32'h0,0,32'h0,            0,1,0,0,0,32'h0,4'h0,32'h0,B);
        v(0,0,0,4'h0,32'h0,32'h0,0,32'h0,            0,0,0,0,0,32'h0,4'h0,32'h0,B);
        run_table("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
